wb_assoc_cache: RTL and testbench



---
 rtl/cache_pkg.sv | 24 ++
 rtl/wb_assoc_cache_if.sv | 31 +++
 rtl/cache_lru_set.sv | 37 +++
 rtl/wb_assoc_cache.sv | 157 +++++++++++++++
 tb/tb_wb_assoc_cache.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split width helpers for the write-back associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WBACK,
    ST_FILL,
    ST_RESP
  } state_e;

  function automatic int off_width(input int blk_bytes);
    return $clog2(blk_bytes);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int sets, input int blk_bytes);
    return addr_w - $clog2(sets) - $clog2(blk_bytes);
  endfunction

endpackage

// File: rtl/wb_assoc_cache_if.sv
// CPU request bus and memory block bus of the cache; slave is the cache side.
interface wb_assoc_cache_if #(
  parameter int ADDR_W    = 32,
  parameter int BLK_BYTES = 64
);
  localparam int BA_W = ADDR_W - $clog2(BLK_BYTES);

  logic                   start;
  logic                   op;
  logic [ADDR_W-1:0]      adr;
  logic [7:0]             i_word;
  logic                   done;
  logic [7:0]             o_word;
  logic                   busy;
  logic                   mem_req;
  logic                   mem_we;
  logic [BA_W-1:0]        mem_adr;
  logic [8*BLK_BYTES-1:0] mem_wblk;
  logic [8*BLK_BYTES-1:0] mem_rblk;
  logic                   mem_ack;

  modport slave (
    input  start, op, adr, i_word, mem_rblk, mem_ack,
    output done, o_word, busy, mem_req, mem_we, mem_adr, mem_wblk
  );

  modport master (
    output start, op, adr, i_word, mem_rblk, mem_ack,
    input  done, o_word, busy, mem_req, mem_we, mem_adr, mem_wblk
  );
endinterface

// File: rtl/cache_lru_set.sv
// Age-based LRU tracker for one set; ages always form a permutation of 0..WAYS-1.
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    touch,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [$clog2(WAYS)-1:0] lru_way
);
  localparam int AGE_W = $clog2(WAYS);

  logic [AGE_W-1:0] age_q [WAYS];
  logic [AGE_W-1:0] old_age;

  assign old_age = age_q[way];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == way)        age_q[w] <= '0;
        else if (age_q[w] < old_age) age_q[w] <= age_q[w] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
  end
endmodule

// File: rtl/wb_assoc_cache.sv
// Write-back, write-allocate set-associative byte cache with LRU replacement
// and one outstanding block transfer (write-back or fill) at a time.
module wb_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int WAYS      = 4,
  parameter int SETS      = 128,
  parameter int BLK_BYTES = 64
) (
  input  logic            clk,
  input  logic            rst_b,
  wb_assoc_cache_if.slave bus
);
  localparam int OFF_W = off_width(BLK_BYTES);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADDR_W, SETS, BLK_BYTES);
  localparam int WAY_W = $clog2(WAYS);
  localparam int BLK_W = 8 * BLK_BYTES;

  state_e state_q, state_d;

  logic             op_q;
  logic [7:0]       wbyte_q;
  logic [OFF_W-1:0] off_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [WAY_W-1:0] way_q;
  logic             gap_q;
  logic [7:0]       o_word_q;

  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  dirty_q  [SETS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [BLK_W-1:0] data_mem [SETS][WAYS];
  logic [WAY_W-1:0] lru_way  [SETS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_dirty;
  logic             lookup_hit;
  logic             wb_ack;
  logic             fill_ack;
  logic [BLK_W-1:0] fill_blk;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = lru_way[idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_q][w] && (tag_mem[idx_q][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx_q][w]) victim_way = WAY_W'(w);
    end
  end

  assign victim_dirty = valid_q[idx_q][victim_way] & dirty_q[idx_q][victim_way];
  assign lookup_hit   = (state_q == ST_LOOKUP) && hit;
  assign wb_ack       = (state_q == ST_WBACK) && bus.mem_ack;
  // gap_q holds mem_req low for one cycle between write-back and fill.
  assign fill_ack     = (state_q == ST_FILL) && bus.mem_ack && !gap_q;

  always_comb begin
    fill_blk = bus.mem_rblk;
    if (op_q) fill_blk[{off_q, 3'b000} +: 8] = wbyte_q;
  end

  always_comb begin
    state_d      = state_q;
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_adr  = {tag_q, idx_q};
    bus.mem_wblk = '0;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               state_d = ST_RESP;
        else if (victim_dirty) state_d = ST_WBACK;
        else                   state_d = ST_FILL;
      end
      ST_WBACK: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_adr  = {tag_mem[idx_q][way_q], idx_q};
        bus.mem_wblk = data_mem[idx_q][way_q];
        if (bus.mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        bus.mem_req = !gap_q;
        if (fill_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_word = o_word_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      gap_q    <= 1'b0;
      o_word_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= wb_ack;
      if (lookup_hit) begin
        if (op_q) dirty_q[idx_q][hit_way] <= 1'b1;
        else      o_word_q <= data_mem[idx_q][hit_way][{off_q, 3'b000} +: 8];
      end
      if (wb_ack) dirty_q[idx_q][way_q] <= 1'b0;
      if (fill_ack) begin
        valid_q[idx_q][way_q] <= 1'b1;
        dirty_q[idx_q][way_q] <= op_q;
        if (!op_q) o_word_q <= bus.mem_rblk[{off_q, 3'b000} +: 8];
      end
    end
  end

  // Request latch, selected way and tag/data arrays carry no reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.start) begin
      op_q                   <= bus.op;
      wbyte_q                <= bus.i_word;
      {tag_q, idx_q, off_q}  <= bus.adr;
    end
    if (state_q == ST_LOOKUP) way_q <= hit ? hit_way : victim_way;
    if (lookup_hit && op_q) data_mem[idx_q][hit_way][{off_q, 3'b000} +: 8] <= wbyte_q;
    if (fill_ack) begin
      tag_mem[idx_q][way_q]  <= tag_q;
      data_mem[idx_q][way_q] <= fill_blk;
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    cache_lru_set #(.WAYS(WAYS)) u_lru (
      .clk     (clk),
      .rst_b   (rst_b),
      .touch   ((state_q == ST_RESP) && (idx_q == IDX_W'(s))),
      .way     (way_q),
      .lru_way (lru_way[s])
    );
  end
endmodule

// File: tb/tb_wb_assoc_cache.sv
// Directed bench for wb_assoc_cache: default geometry plus a 2-way/16-set/16-byte instance.
module tb_wb_assoc_cache;
  logic clk = 1'b0;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  wb_assoc_cache_if #(.ADDR_W(32), .BLK_BYTES(64)) bus ();
  wb_assoc_cache_if #(.ADDR_W(32), .BLK_BYTES(16)) bus_s ();

  wb_assoc_cache #(.ADDR_W(32), .WAYS(4), .SETS(128), .BLK_BYTES(64)) u_dut (
    .clk(clk), .rst_b(rst_b), .bus(bus)
  );

  wb_assoc_cache #(.ADDR_W(32), .WAYS(2), .SETS(16), .BLK_BYTES(16)) u_dut_s (
    .clk(clk), .rst_b(rst_b), .bus(bus_s)
  );

  always @(negedge clk) begin
    if (bus.mem_req && !req_prev) req_rises++;
    req_prev = bus.mem_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] mk_blk(input logic [7:0] base);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic cpu_issue(input logic op, input logic [31:0] a, input logic [7:0] b);
    int n = 0;
    while (bus.busy && n < 60) begin @(negedge clk); n++; end
    bus.op = op; bus.adr = a; bus.i_word = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.adr = ~a; bus.i_word = ~b;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    if (bus.done !== 1'b1) cyc = -1;
  endtask

  task automatic mem_serve(input string nm, input logic we_exp, input logic [25:0] adr_exp,
                           input logic [511:0] rblk, input logic [511:0] wblk_exp, input logic chk_wblk);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (bus.mem_req !== 1'b1) begin
      $display("FAIL %s_req: mem_req got %b want 1", nm, bus.mem_req); fails++;
      return;
    end
    tests++;
    if (bus.mem_we !== we_exp) begin
      $display("FAIL %s_we: got %b want %b", nm, bus.mem_we, we_exp); fails++;
    end
    tests++;
    if (bus.mem_adr !== adr_exp) begin
      $display("FAIL %s_adr: got %h want %h", nm, bus.mem_adr, adr_exp); fails++;
    end
    if (chk_wblk) begin
      tests++;
      if (bus.mem_wblk !== wblk_exp) begin
        $display("FAIL %s_wblk: got %h want %h", nm, bus.mem_wblk, wblk_exp); fails++;
      end
    end
    @(negedge clk);
    tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_adr !== adr_exp) begin
      $display("FAIL %s_hold: req/adr got %b/%h want 1/%h", nm, bus.mem_req, bus.mem_adr, adr_exp); fails++;
    end
    bus.mem_rblk = rblk; bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL %s_drop: mem_req got %b want 0", nm, bus.mem_req); fails++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    tests++;
    if ({bus.done, bus.busy, bus.mem_req, bus.mem_we} !== 4'b0000) begin
      $display("FAIL reset_ctl: done/busy/req/we got %b want 0000", {bus.done, bus.busy, bus.mem_req, bus.mem_we}); fails++;
    end
    tests++;
    if (bus.o_word !== 8'h00) begin
      $display("FAIL reset_oword: got %h want 00", bus.o_word); fails++;
    end
    tests++;
    if ({bus_s.done, bus_s.busy, bus_s.mem_req} !== 3'b000) begin
      $display("FAIL reset_small: done/busy/req got %b want 000", {bus_s.done, bus_s.busy, bus_s.mem_req}); fails++;
    end
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL reset_release_busy: got %b want 0", bus.busy); fails++;
    end
  endtask

  task automatic test_read_miss_hit();
    int cyc, r0;
    cpu_issue(1'b0, 32'h0000_0040, 8'h00);
    mem_serve("rd_fill", 1'b0, 26'h1, mk_blk(8'hA5), '0, 1'b0);
    wait_done(cyc);
    tests++;
    if (cyc < 0) begin $display("FAIL rd_miss_done: got timeout want done"); fails++; end
    tests++;
    if (bus.o_word !== 8'hA5) begin $display("FAIL rd_miss_oword: got %h want a5", bus.o_word); fails++; end
    r0 = req_rises;
    cpu_issue(1'b0, 32'h0000_0040, 8'h00);
    wait_done(cyc);
    tests++;
    if (cyc !== 2) begin $display("FAIL rd_hit_latency: got %0d want 2", cyc); fails++; end
    tests++;
    if (bus.o_word !== 8'hA5) begin $display("FAIL rd_hit_oword: got %h want a5", bus.o_word); fails++; end
    tests++;
    if (req_rises !== r0) begin $display("FAIL rd_hit_noreq: mem_req pulses got %0d want 0", req_rises - r0); fails++; end
  endtask

  task automatic test_write_hit();
    int cyc, r0;
    r0 = req_rises;
    cpu_issue(1'b1, 32'h0000_0041, 8'h5C);
    wait_done(cyc);
    tests++;
    if (cyc !== 2) begin $display("FAIL wr_hit_latency: got %0d want 2", cyc); fails++; end
    cpu_issue(1'b0, 32'h0000_0041, 8'h00);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'h5C) begin $display("FAIL wr_hit_readback: got %h want 5c", bus.o_word); fails++; end
    cpu_issue(1'b0, 32'h0000_0040, 8'h00);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'hA5) begin $display("FAIL wr_hit_neighbour: got %h want a5", bus.o_word); fails++; end
    tests++;
    if (req_rises !== r0) begin $display("FAIL wr_hit_noreq: mem_req pulses got %0d want 0", req_rises - r0); fails++; end
  endtask

  task automatic test_lru();
    int cyc, r0;
    logic [7:0] exp_t [3];
    exp_t[0] = 8'hA5; exp_t[1] = 8'h10; exp_t[2] = 8'h20;
    for (int t = 1; t <= 3; t++) begin
      cpu_issue(1'b0, 32'(t) * 32'h2000 + 32'h40, 8'h00);
      mem_serve("lru_fill", 1'b0, 26'(t * 128 + 1), mk_blk(8'(16 * t)), '0, 1'b0);
      wait_done(cyc);
      tests++;
      if (bus.o_word !== 8'(16 * t)) begin
        $display("FAIL lru_fill_oword: tag %0d got %h want %h", t, bus.o_word, 8'(16 * t)); fails++;
      end
    end
    for (int t = 0; t < 3; t++) begin
      r0 = req_rises;
      cpu_issue(1'b0, 32'(t) * 32'h2000 + 32'h40, 8'h00);
      wait_done(cyc);
      tests++;
      if (cyc !== 2 || req_rises !== r0 || bus.o_word !== exp_t[t]) begin
        $display("FAIL lru_touch: tag %0d cyc/req/oword got %0d/%0d/%h want 2/0/%h", t, cyc, req_rises - r0, bus.o_word, exp_t[t]); fails++;
      end
    end
    r0 = req_rises;
    cpu_issue(1'b0, 32'h0000_8040, 8'h00);
    mem_serve("lru_victim", 1'b0, 26'h201, mk_blk(8'h40), '0, 1'b0);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'h40) begin $display("FAIL lru_victim_oword: got %h want 40", bus.o_word); fails++; end
    tests++;
    if (req_rises - r0 !== 1) begin $display("FAIL lru_victim_pulses: got %0d want 1", req_rises - r0); fails++; end
  endtask

  task automatic test_dirty_evict();
    int cyc, r0;
    logic [511:0] wexp;
    wexp = mk_blk(8'hA5);
    wexp[15:8] = 8'h5C;
    r0 = req_rises;
    cpu_issue(1'b0, 32'h0000_6040, 8'h00);
    mem_serve("wback", 1'b1, 26'h001, '0, wexp, 1'b1);
    mem_serve("refill", 1'b0, 26'h181, mk_blk(8'h30), '0, 1'b0);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'h30) begin $display("FAIL evict_oword: got %h want 30", bus.o_word); fails++; end
    tests++;
    if (req_rises - r0 !== 2) begin $display("FAIL evict_pulses: got %0d want 2", req_rises - r0); fails++; end
  endtask

  task automatic test_ignored();
    int cyc, r0, n;
    r0 = req_rises;
    cpu_issue(1'b0, 32'h0000_0080, 8'h00);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.adr = 32'h0000_00C0; bus.i_word = 8'hEE;
    @(negedge clk);
    bus.start = 1'b0;
    mem_serve("busy_fill", 1'b0, 26'h2, mk_blk(8'h70), '0, 1'b0);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'h70) begin $display("FAIL busy_start_oword: got %h want 70", bus.o_word); fails++; end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || req_rises - r0 !== 1) begin
      $display("FAIL busy_start_ignored: busy/pulses got %b/%0d want 0/1", bus.busy, req_rises - r0); fails++;
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.mem_req} !== 3'b000) begin
      $display("FAIL idle_ack: busy/done/req got %b want 000", {bus.busy, bus.done, bus.mem_req}); fails++;
    end
    cpu_issue(1'b0, 32'h0000_00C0, 8'h00);
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (bus.mem_req !== 1'b1) begin $display("FAIL rst_fill_req: got %b want 1", bus.mem_req); fails++; end
    #2 rst_b = 1'b0;
    #1;
    tests++;
    if ({bus.done, bus.busy, bus.mem_req, bus.mem_we} !== 4'b0000 || bus.o_word !== 8'h00) begin
      $display("FAIL rst_mid_fill: ctl/oword got %b/%h want 0000/00", {bus.done, bus.busy, bus.mem_req, bus.mem_we}, bus.o_word); fails++;
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      $display("FAIL rst_late_ack: busy/done got %b want 00", {bus.busy, bus.done}); fails++;
    end
    cpu_issue(1'b0, 32'h0000_00C0, 8'h00);
    mem_serve("rst_remiss", 1'b0, 26'h3, mk_blk(8'h90), '0, 1'b0);
    wait_done(cyc);
    tests++;
    if (bus.o_word !== 8'h90) begin $display("FAIL rst_remiss_oword: got %h want 90", bus.o_word); fails++; end
  endtask

  task automatic test_small();
    int n, cyc;
    logic saw_req;
    logic [127:0] blk;
    for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'hA5 + 8'(i);
    bus_s.op = 1'b0; bus_s.adr = 32'h0000_0040; bus_s.i_word = 8'h00; bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0; bus_s.adr = 32'hFFFF_FFFF;
    n = 0;
    while (bus_s.mem_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (bus_s.mem_req !== 1'b1 || bus_s.mem_we !== 1'b0 || bus_s.mem_adr !== 28'h4) begin
      $display("FAIL small_fill: req/we/adr got %b/%b/%h want 1/0/0000004", bus_s.mem_req, bus_s.mem_we, bus_s.mem_adr); fails++;
    end
    bus_s.mem_rblk = blk; bus_s.mem_ack = 1'b1;
    @(negedge clk);
    bus_s.mem_ack = 1'b0;
    n = 0;
    while (bus_s.done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (bus_s.done !== 1'b1 || bus_s.o_word !== 8'hA5) begin
      $display("FAIL small_miss: done/oword got %b/%h want 1/a5", bus_s.done, bus_s.o_word); fails++;
    end
    @(negedge clk);
    bus_s.adr = 32'h0000_0040; bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    cyc = 1; saw_req = 1'b0;
    while (bus_s.done !== 1'b1 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (bus_s.mem_req) saw_req = 1'b1;
    end
    tests++;
    if (cyc !== 2 || saw_req !== 1'b0 || bus_s.o_word !== 8'hA5) begin
      $display("FAIL small_hit: cyc/req/oword got %0d/%b/%h want 2/0/a5", cyc, saw_req, bus_s.o_word); fails++;
    end
  endtask

  initial begin
    rst_b = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.adr = '0; bus.i_word = '0;
    bus.mem_rblk = '0; bus.mem_ack = 1'b0;
    bus_s.start = 1'b0; bus_s.op = 1'b0; bus_s.adr = '0; bus_s.i_word = '0;
    bus_s.mem_rblk = '0; bus_s.mem_ack = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_lru();
    test_dirty_evict();
    test_ignored();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
